// File: rtl/sync_fifo_flags_if.sv
// Handshake bundle between a producer/consumer pair and sync_fifo_flags.
// The FIFO takes the slave side and the block that feeds and drains it takes the master side.
interface sync_fifo_flags_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3
);
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  rd_en;
  logic                  clr_err;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [ADDR_WIDTH:0]   count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output wr_en, wr_data, rd_en, clr_err,
    input  rd_data, rd_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

  modport slave (
    input  wr_en, wr_data, rd_en, clr_err,
    output rd_data, rd_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with occupancy count, almost-full/almost-empty thresholds,
// standard or first-word-fall-through read mode, and sticky overflow/underflow flags.
module sync_fifo_flags #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3,
  parameter int AF_LEVEL   = 6,
  parameter int AE_LEVEL   = 1,
  parameter int FWFT       = 0
) (
  input logic              clk,
  input logic              rst,
  sync_fifo_flags_if.slave bus
);

  localparam int                DEPTH   = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AF_C    = (ADDR_WIDTH+1)'(AF_LEVEL);
  localparam logic [ADDR_WIDTH:0] AE_C    = (ADDR_WIDTH+1)'(AE_LEVEL);
  localparam logic [ADDR_WIDTH:0] ZERO_C  = {(ADDR_WIDTH+1){1'b0}};
  localparam logic [ADDR_WIDTH:0] ONE_C   = (ADDR_WIDTH+1)'(1);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_WIDTH:0]   wptr_q, wptr_d;
  logic [ADDR_WIDTH:0]   rptr_q, rptr_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;
  logic [ADDR_WIDTH:0]   count_s;
  logic                  full_s;
  logic                  empty_s;
  logic                  wr_ok_s;
  logic                  rd_ok_s;

  // Status decodes come only from registered pointers, never from this cycle's requests.
  assign count_s = wptr_q - rptr_q;
  assign full_s  = (count_s == DEPTH_C);
  assign empty_s = (count_s == ZERO_C);

  // A write into a full FIFO is still accepted when a pop frees the head slot on the same edge.
  assign wr_ok_s = bus.wr_en && (!full_s || bus.rd_en);
  assign rd_ok_s = bus.rd_en && !empty_s;

  // Next-state for pointers and sticky error flags.
  always_comb begin
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (wr_ok_s) begin
      wptr_d = wptr_q + ONE_C;
    end else begin
      wptr_d = wptr_q;
    end
    if (rd_ok_s) begin
      rptr_d = rptr_q + ONE_C;
    end else begin
      rptr_d = rptr_q;
    end
    if (bus.wr_en && full_s && !bus.rd_en) begin
      overflow_d = 1'b1;
    end else if (bus.clr_err) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end
    if (bus.rd_en && empty_s) begin
      underflow_d = 1'b1;
    end else if (bus.clr_err) begin
      underflow_d = 1'b0;
    end else begin
      underflow_d = underflow_q;
    end
  end

  // Pointer and error-flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q      <= ZERO_C;
      rptr_q      <= ZERO_C;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage array; deliberately unreset.
  always_ff @(posedge clk) begin
    if (wr_ok_s) begin
      mem_q[wptr_q[ADDR_WIDTH-1:0]] <= bus.wr_data;
    end
  end

  assign bus.count        = count_s;
  assign bus.full         = full_s;
  assign bus.empty        = empty_s;
  assign bus.almost_full  = (count_s >= AF_C);
  assign bus.almost_empty = (count_s <= AE_C);
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;

  if (FWFT != 0) begin : g_fwft
    assign bus.rd_data  = mem_q[rptr_q[ADDR_WIDTH-1:0]];
    assign bus.rd_valid = !empty_s;
  end else begin : g_std
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                  rd_valid_q, rd_valid_d;

    // Capture the head word on an accepted pop; hold the last word otherwise.
    always_comb begin
      rd_data_d  = rd_data_q;
      rd_valid_d = 1'b0;
      if (rd_ok_s) begin
        rd_data_d  = mem_q[rptr_q[ADDR_WIDTH-1:0]];
        rd_valid_d = 1'b1;
      end else begin
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
      end
    end

    // Registered read port.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        rd_data_q  <= {DATA_WIDTH{1'b0}};
        rd_valid_q <= 1'b0;
      end else begin
        rd_data_q  <= rd_data_d;
        rd_valid_q <= rd_valid_d;
      end
    end

    assign bus.rd_data  = rd_data_q;
    assign bus.rd_valid = rd_valid_q;
  end

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Directed bench for sync_fifo_flags: one standard-read and one FWFT instance,
// expected read words queued at stimulus time and checked by a negedge monitor.
module tb_sync_fifo_flags;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sync_fifo_flags_if #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) b0 ();
  sync_fifo_flags_if #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) b1 ();

  sync_fifo_flags #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .AF_LEVEL(6), .AE_LEVEL(1), .FWFT(0))
    dut0 (.clk(clk), .rst(rst), .bus(b0.slave));
  sync_fifo_flags #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .AF_LEVEL(6), .AE_LEVEL(1), .FWFT(1))
    dut1 (.clk(clk), .rst(rst), .bus(b1.slave));

  int checks = 0;
  int errors = 0;
  logic [7:0] q0 [$];
  logic [7:0] q1 [$];
  logic [7:0] e0;
  logic [7:0] e1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle0;
    b0.wr_en = 1'b0; b0.rd_en = 1'b0; b0.clr_err = 1'b0; b0.wr_data = 8'h00;
  endtask

  task automatic idle1;
    b1.wr_en = 1'b0; b1.rd_en = 1'b0; b1.clr_err = 1'b0; b1.wr_data = 8'h00;
  endtask

  task automatic chk_reset0(input string tag);
    chk({tag, "_count"}, b0.count, 32'd0);
    chk({tag, "_empty"}, b0.empty, 32'd1);
    chk({tag, "_full"}, b0.full, 32'd0);
    chk({tag, "_ae"}, b0.almost_empty, 32'd1);
    chk({tag, "_af"}, b0.almost_full, 32'd0);
    chk({tag, "_ovf"}, b0.overflow, 32'd0);
    chk({tag, "_unf"}, b0.underflow, 32'd0);
    chk({tag, "_rd_valid"}, b0.rd_valid, 32'd0);
    chk({tag, "_rd_data"}, b0.rd_data, 32'd0);
  endtask

  // Monitor: every presented/popped word must match the head of its expectation queue.
  always @(negedge clk) begin
    if (!rst) begin
      if (b0.rd_valid === 1'b1) begin
        if (q0.size() == 0) begin
          chk("rd0_unexpected_valid", b0.rd_valid, 32'd0);
        end else begin
          e0 = q0.pop_front();
          chk("rd0_data", b0.rd_data, e0);
        end
      end
      if (b1.rd_en === 1'b1 && q1.size() != 0) begin
        e1 = q1.pop_front();
        chk("rd1_valid", b1.rd_valid, 32'd1);
        chk("rd1_data", b1.rd_data, e1);
      end
    end
  end

  initial begin
    idle0();
    idle1();
    #12;
    chk_reset0("rst0");
    chk("rst1_rd_valid", b1.rd_valid, 32'd0);
    chk("rst1_empty", b1.empty, 32'd1);
    tick();
    rst = 1'b0;
    tick();

    // Fill 0x01..0x08.
    for (int i = 0; i < 8; i++) begin
      b0.wr_en = 1'b1;
      b0.wr_data = 8'(i + 1);
      tick();
      chk("fill_count", b0.count, 32'(i + 1));
      chk("fill_af", b0.almost_full, 32'((i + 1) >= 6));
      chk("fill_full", b0.full, 32'((i + 1) == 8));
      chk("fill_empty", b0.empty, 32'd0);
    end
    b0.wr_data = 8'hFF;
    tick();
    idle0();
    chk("ovf_set", b0.overflow, 32'd1);
    chk("ovf_count", b0.count, 32'd8);

    // Drain 0x01..0x08, then one read too many.
    for (int i = 0; i < 8; i++) begin
      b0.rd_en = 1'b1;
      q0.push_back(8'(i + 1));
      tick();
      chk("drain_rd_valid", b0.rd_valid, 32'd1);
      chk("drain_count", b0.count, 32'(7 - i));
      chk("drain_ae", b0.almost_empty, 32'((7 - i) <= 1));
      chk("drain_empty", b0.empty, 32'(i == 7));
    end
    tick();
    idle0();
    chk("unf_rd_valid", b0.rd_valid, 32'd0);
    chk("unf_set", b0.underflow, 32'd1);
    chk("unf_count", b0.count, 32'd0);

    // Simultaneous read+write on empty: write wins, read rejected.
    b0.wr_en = 1'b1; b0.rd_en = 1'b1; b0.wr_data = 8'h55;
    tick();
    idle0();
    chk("erw_count", b0.count, 32'd1);
    chk("erw_unf", b0.underflow, 32'd1);
    chk("erw_rd_valid", b0.rd_valid, 32'd0);
    b0.rd_en = 1'b1;
    q0.push_back(8'h55);
    tick();
    idle0();
    chk("erw_read_valid", b0.rd_valid, 32'd1);
    chk("erw_read_empty", b0.empty, 32'd1);

    // Clear with a coincident underflow: new error keeps UNDERFLOW, OVERFLOW clears.
    b0.clr_err = 1'b1; b0.rd_en = 1'b1;
    tick();
    idle0();
    chk("clr_prio_unf", b0.underflow, 32'd1);
    chk("clr_ovf", b0.overflow, 32'd0);
    b0.clr_err = 1'b1;
    tick();
    idle0();
    chk("clr_unf", b0.underflow, 32'd0);
    chk("clr_ovf2", b0.overflow, 32'd0);

    // Refill, then read+write while full.
    for (int i = 0; i < 8; i++) begin
      b0.wr_en = 1'b1;
      b0.wr_data = 8'(i + 1);
      tick();
    end
    idle0();
    chk("refill_full", b0.full, 32'd1);
    b0.wr_en = 1'b1; b0.rd_en = 1'b1; b0.wr_data = 8'hAA;
    q0.push_back(8'h01);
    tick();
    idle0();
    chk("frw_count", b0.count, 32'd8);
    chk("frw_full", b0.full, 32'd1);
    chk("frw_ovf", b0.overflow, 32'd0);
    chk("frw_rd_valid", b0.rd_valid, 32'd1);
    for (int i = 0; i < 8; i++) begin
      b0.rd_en = 1'b1;
      q0.push_back((i < 7) ? 8'(i + 2) : 8'hAA);
      tick();
    end
    idle0();
    chk("frw_empty", b0.empty, 32'd1);
    tick();

    // FWFT: written word appears without a read request.
    b1.wr_en = 1'b1; b1.wr_data = 8'h3C;
    tick();
    idle1();
    chk("fwft_valid", b1.rd_valid, 32'd1);
    chk("fwft_data", b1.rd_data, 32'h3C);
    chk("fwft_count", b1.count, 32'd1);
    tick();
    chk("fwft_hold", b1.rd_data, 32'h3C);
    for (int k = 0; k < 20; k++) begin
      b1.wr_en = 1'b1; b1.rd_en = 1'b1; b1.wr_data = 8'(8'h40 + k);
      q1.push_back((k == 0) ? 8'h3C : 8'(8'h40 + k - 1));
      tick();
      chk("fwft_stream_count", b1.count, 32'd1);
    end
    b1.wr_en = 1'b0; b1.rd_en = 1'b1;
    q1.push_back(8'h53);
    tick();
    idle1();
    chk("fwft_end_empty", b1.empty, 32'd1);
    chk("fwft_end_valid", b1.rd_valid, 32'd0);

    // Asynchronous reset with five words stored.
    for (int i = 0; i < 5; i++) begin
      b0.wr_en = 1'b1;
      b0.wr_data = 8'(8'h10 + i);
      tick();
    end
    idle0();
    b0.wr_en = 1'b1; b0.rd_en = 1'b1;
    tick();
    chk("pre_rst_count", b0.count, 32'd5);
    b0.wr_en = 1'b0; b0.rd_en = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk_reset0("async_rst");
    tick();
    rst = 1'b0;
    tick();
    chk("post_rst_empty", b0.empty, 32'd1);

    chk("q0_drained", 32'(q0.size()), 32'd0);
    chk("q1_drained", 32'(q1.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
